// File: rtl/pkt_sync_fifo_if.sv
// Handshake bundle between a packet producer/consumer and pkt_sync_fifo.
// The master side is the producer/consumer pair, the slave side is the FIFO.
interface pkt_sync_fifo_if #(
  parameter int FIFO_WIDTH = 32,
  parameter int PTR_WIDTH  = 7
);
  logic [FIFO_WIDTH-1:0] data_i;
  logic                  push_i;
  logic                  last_i;
  logic                  drop_i;
  logic                  pop_i;
  logic [FIFO_WIDTH-1:0] data_o;
  logic                  last_o;
  logic                  full_o;
  logic                  a_full_o;
  logic                  empty_o;
  logic                  a_empty_o;
  logic [PTR_WIDTH:0]    data_cnt_o;
  logic [PTR_WIDTH:0]    pkt_cnt_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output data_i, push_i, last_i, drop_i, pop_i,
    input  data_o, last_o, full_o, a_full_o, empty_o, a_empty_o,
           data_cnt_o, pkt_cnt_o, overflow_o, underflow_o
  );

  modport slave (
    input  data_i, push_i, last_i, drop_i, pop_i,
    output data_o, last_o, full_o, a_full_o, empty_o, a_empty_o,
           data_cnt_o, pkt_cnt_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/pkt_sync_fifo.sv
// Single-clock packet FIFO with commit/drop. Words are written speculatively
// at wr_ptr and only become visible to the read side once the packet's last
// word moves cmt_ptr forward. Standard or first-word-fall-through read mode.
//
// Write FSM states:
//   state      | meaning
//   WR_IDLE    | between packets, next accepted push starts a packet
//   WR_IN_PKT  | packet partially written, words uncommitted
//   WR_DISCARD | packet truncated by full, swallow pushes until its last word
module pkt_sync_fifo #(
  parameter int FIFO_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 128,
  parameter int FWFT        = 0,
  parameter int A_FULL_THR  = 120,
  parameter int A_EMPTY_THR = 4,
  parameter int PTR_WIDTH   = $clog2(FIFO_DEPTH)
) (
  input logic            clk_i,
  input logic            rstn_i,
  pkt_sync_fifo_if.slave bus
);

  typedef logic [PTR_WIDTH:0] ptr_t;

  localparam bit   IS_FWFT   = (FWFT != 0);
  localparam ptr_t DEPTH_P   = ptr_t'(FIFO_DEPTH);
  localparam ptr_t A_FULL_P  = ptr_t'(A_FULL_THR);
  localparam ptr_t A_EMPTY_P = ptr_t'(A_EMPTY_THR);

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_IN_PKT  = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_t;

  // Extra top bit of each entry carries the packet's last flag.
  logic [FIFO_WIDTH:0] mem [FIFO_DEPTH];

  wr_state_t state, state_nxt;
  ptr_t wr_ptr, cmt_ptr, rd_ptr, cmt_q, pkt_cnt;
  ptr_t wr_nxt, cmt_nxt, rd_nxt, cmt_view, pkt_nxt, out_addr;
  ptr_t used_nxt, avail_nxt;

  logic                  push_acc, commit, ovf_nxt;
  logic                  pop_acc, pop_last, empty_nxt, load_out;
  logic                  full_q, a_full_q, empty_q, a_empty_q, ovf_q, udf_q;
  logic [FIFO_WIDTH-1:0] data_q;
  logic                  last_q;

  // Write-side FSM: push acceptance, commit, drop and overflow handling.
  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cmt_nxt   = cmt_ptr;
    push_acc  = 1'b0;
    commit    = 1'b0;
    ovf_nxt   = 1'b0;
    if (bus.drop_i) begin
      wr_nxt    = cmt_ptr;
      state_nxt = WR_IDLE;
    end else begin
      case (state)
        WR_DISCARD: begin
          if (bus.push_i && bus.last_i) state_nxt = WR_IDLE;
        end
        default: begin
          if (bus.push_i) begin
            if (full_q) begin
              // Truncated packet: rewind and swallow the rest. A rejected
              // last word already ends the packet, so no discard phase then.
              wr_nxt    = cmt_ptr;
              ovf_nxt   = 1'b1;
              state_nxt = bus.last_i ? WR_IDLE : WR_DISCARD;
            end else begin
              push_acc = 1'b1;
              wr_nxt   = wr_ptr + ptr_t'(1);
              if (bus.last_i) begin
                cmt_nxt   = wr_ptr + ptr_t'(1);
                commit    = 1'b1;
                state_nxt = WR_IDLE;
              end else begin
                state_nxt = WR_IN_PKT;
              end
            end
          end
        end
      endcase
    end
  end

  // Read side and status flags computed from the next-state pointers.
  // FWFT looks at a delayed commit pointer so the prefetch into the output
  // register lands one edge later than the standard-mode empty release.
  always_comb begin
    pop_acc   = bus.pop_i && !empty_q;
    rd_nxt    = rd_ptr + ptr_t'(pop_acc);
    pop_last  = mem[rd_ptr[PTR_WIDTH-1:0]][FIFO_WIDTH];
    cmt_view  = IS_FWFT ? cmt_q : cmt_ptr;
    empty_nxt = (cmt_view == rd_nxt);
    avail_nxt = cmt_view - rd_nxt;
    used_nxt  = wr_nxt - rd_nxt;
    pkt_nxt   = pkt_cnt + ptr_t'(commit) - ptr_t'(pop_acc && pop_last);
    if (IS_FWFT) begin
      load_out = !empty_nxt && (empty_q || pop_acc);
      out_addr = rd_nxt;
    end else begin
      load_out = pop_acc;
      out_addr = rd_ptr;
    end
  end

  // Storage write; RAM contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_ptr[PTR_WIDTH-1:0]] <= {bus.last_i, bus.data_i};
  end

  // Pointer, counter, flag and output-register state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= WR_IDLE;
      wr_ptr    <= '0;
      cmt_ptr   <= '0;
      rd_ptr    <= '0;
      cmt_q     <= '0;
      pkt_cnt   <= '0;
      full_q    <= 1'b0;
      a_full_q  <= 1'b0;
      empty_q   <= 1'b1;
      a_empty_q <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_nxt;
      cmt_ptr   <= cmt_nxt;
      rd_ptr    <= rd_nxt;
      cmt_q     <= cmt_ptr;
      pkt_cnt   <= pkt_nxt;
      full_q    <= (used_nxt == DEPTH_P);
      a_full_q  <= (used_nxt >= A_FULL_P);
      empty_q   <= empty_nxt;
      a_empty_q <= (avail_nxt <= A_EMPTY_P);
      ovf_q     <= ovf_nxt;
      udf_q     <= bus.pop_i && empty_q;
      if (load_out) begin
        data_q <= mem[out_addr[PTR_WIDTH-1:0]][FIFO_WIDTH-1:0];
        last_q <= mem[out_addr[PTR_WIDTH-1:0]][FIFO_WIDTH];
      end
    end
  end

  assign bus.data_o      = data_q;
  assign bus.last_o      = last_q;
  assign bus.full_o      = full_q;
  assign bus.a_full_o    = a_full_q;
  assign bus.empty_o     = empty_q;
  assign bus.a_empty_o   = a_empty_q;
  assign bus.data_cnt_o  = cmt_ptr - rd_ptr;
  assign bus.pkt_cnt_o   = pkt_cnt;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = udf_q;

endmodule
